// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps at most one request in flight to a
// variable-latency instruction memory and presents PC/instruction pairs to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Branch_i,
  input  logic [31:0] Branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PC_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,   // no request in flight, ready to issue at pc_q
    S_WAIT,   // request in flight, response will be kept
    S_DROP,   // request in flight, response will be thrown away after a redirect
    S_VALID   // instr_q holds a fetched instruction for pc_q
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_seq;
  logic [31:0] target_aligned;
  logic        advance;

  assign pc_seq         = pc_q + PC_STEP;
  assign target_aligned = Branch_target_i & ~32'h0000_0003;
  assign advance        = (state_q == S_VALID) && !Branch_i && !Stall_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create ordering-dependent simulation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can leave it unassigned
  // and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: begin
        if (Branch_i) pc_d    = target_aligned;
        else          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Branch_i) begin
          pc_d    = target_aligned;
          state_d = imem_rvalid_i ? S_IDLE : S_DROP;
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = S_VALID;
        end
      end
      S_DROP: begin
        if (Branch_i)      pc_d    = target_aligned;
        if (imem_rvalid_i) state_d = S_IDLE;
      end
      S_VALID: begin
        if (Branch_i) begin
          pc_d    = target_aligned;
          state_d = S_IDLE;
        end else if (!Stall_i) begin
          pc_d    = pc_seq;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The IDLE request is gated by rst_i so the strobe is low while reset is held.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    unique case (state_q)
      S_IDLE:  imem_req_o = rst_i && !Branch_i;
      S_VALID: begin
        if (advance) begin
          imem_req_o  = 1'b1;
          imem_addr_o = pc_seq;
        end
      end
      default: imem_req_o = 1'b0;
    endcase
    valid_o = (state_q == S_VALID);
    instr_o = valid_o ? instr_q : 32'h0000_0000;
    PC_o    = pc_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then randomized traffic,
// compared each cycle against a transaction-level model of the fetch front end.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i;
  logic        rst_i;
  logic        Stall_i;
  logic        Branch_i;
  logic [31:0] Branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] PC_o;
  logic [31:0] instr_o;
  logic        valid_o;

  if_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .Stall_i         (Stall_i),
    .Branch_i        (Branch_i),
    .Branch_target_i (Branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .PC_o            (PC_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: what the fetch unit is holding, expressed as plain facts.
  logic [31:0] m_pc;
  logic        m_busy;     // a memory request is in flight
  logic        m_discard;  // the in-flight response belongs to a squashed path
  logic        m_have;     // an instruction is being presented
  logic [31:0] m_instr;

  // Memory model: one pending response with a countdown.
  int          resp_cnt;
  logic [31:0] resp_data;
  int          lat_min, lat_max;
  bit          stray_en, stray_now;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0093;
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_have    = 1'b0;
    m_instr   = '0;
    resp_cnt  = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs, advance the model.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tg);
    logic        e_req;
    logic [31:0] e_addr;
    Stall_i         = st;
    Branch_i        = br;
    Branch_target_i = tg;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = $urandom;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = resp_data;
      end
    end else if (stray_now || (stray_en && $urandom_range(0, 15) == 0)) begin
      imem_rvalid_i = 1'b1;
    end
    stray_now = 1'b0;
    #1;
    e_req  = !m_busy && !br && (!m_have || !st);
    e_addr = m_have ? m_pc + 32'd4 : m_pc;
    check("req", 32'(imem_req_o), 32'(e_req));
    if (e_req) check("addr", imem_addr_o, e_addr);
    check("valid", 32'(valid_o), 32'(m_have));
    check("instr", instr_o, m_have ? m_instr : 32'h0);
    check("pc", PC_o, m_pc);

    if (br) begin
      m_pc   = tg & 32'hFFFF_FFFC;
      m_have = 1'b0;
      if (m_busy && imem_rvalid_i) begin
        m_busy    = 1'b0;
        m_discard = 1'b0;
      end else if (m_busy) begin
        m_discard = 1'b1;
      end
    end else if (m_busy && imem_rvalid_i) begin
      m_busy = 1'b0;
      if (!m_discard) begin
        m_have  = 1'b1;
        m_instr = imem_rdata_i;
      end
      m_discard = 1'b0;
    end else if (e_req) begin
      if (m_have) m_pc = m_pc + 32'd4;
      m_have = 1'b0;
      m_busy = 1'b1;
    end
    if (e_req) begin
      resp_cnt  = int'($urandom_range(lat_min, lat_max));
      resp_data = mem_word(e_addr);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i           = 1'b0;
    Stall_i         = 1'b0;
    Branch_i        = 1'b0;
    Branch_target_i = '0;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = '0;
    lat_min         = 1;
    lat_max         = 1;
    stray_en        = 1'b0;
    stray_now       = 1'b0;
    model_reset();

    // Reset values while reset is held.
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_req", 32'(imem_req_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", PC_o, RESET_PC);
    rst_i = 1'b1;

    // First fetch, 1-cycle memory.
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("first_valid", 32'(valid_o), 32'h1);
    check("first_pc", PC_o, 32'h0);
    check("first_instr", instr_o, 32'h0000_0093);

    // Stall held five cycles in VALID.
    repeat (5) cycle(1, 0, 0);
    check("stall_valid", 32'(valid_o), 32'h1);
    check("stall_pc", PC_o, 32'h0);
    check("stall_instr", instr_o, 32'h0000_0093);

    // Release issues pc+4; branch while waiting, response arrives 3 cycles later.
    lat_min = 4; lat_max = 4;
    cycle(0, 0, 0);
    cycle(0, 1, 32'h0000_0100);
    check("br_wait_pc", PC_o, 32'h0000_0100);
    check("br_wait_valid", 32'(valid_o), 32'h0);
    lat_min = 1; lat_max = 1;
    repeat (3) cycle(0, 0, 0);
    check("drop_valid", 32'(valid_o), 32'h0);
    check("drop_instr", instr_o, 32'h0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Branch and stall together in VALID, unaligned target.
    cycle(1, 1, 32'h0000_0042);
    check("brst_pc", PC_o, 32'h0000_0040);
    check("brst_valid", 32'(valid_o), 32'h0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Wrap of the sequential PC.
    cycle(0, 1, 32'hFFFF_FFFE);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("wrap_pre_pc", PC_o, 32'hFFFF_FFFC);
    check("wrap_pre_valid", 32'(valid_o), 32'h1);
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0);
    check("wrap_pc", PC_o, 32'h0000_0000);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Asynchronous reset in the middle of a request.
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req_o), 32'h0);
    check("mid_rst_valid", 32'(valid_o), 32'h0);
    check("mid_rst_instr", instr_o, 32'h0);
    check("mid_rst_pc", PC_o, RESET_PC);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i     = 1'b1;
    lat_min   = 1; lat_max = 1;
    stray_now = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("post_rst_valid", 32'(valid_o), 32'h1);

    // Randomized traffic.
    stray_en = 1'b1;
    lat_min  = 1; lat_max = 4;
    repeat (3000) begin
      logic        st, br;
      logic [31:0] tg;
      st = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 9) == 0);
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(st, br, tg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
